// File: rtl/router_xy_input.sv
// Mesh router input port: beat FIFO plus X-then-Y route selection.
// Route is taken from the header beat and held for the packet body.
`ifndef ROUTER_BUS_W
`define ROUTER_BUS_W 32
`endif

package router_pkg;

  typedef enum logic [2:0] {
    P_LOCAL = 3'd0,
    P_EAST  = 3'd1,
    P_WEST  = 3'd2,
    P_NORTH = 3'd3,
    P_SOUTH = 3'd4
  } port_e;

  typedef enum logic {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } rt_state_e;

  function automatic port_e route_xy(
    input logic [3:0] dx,
    input logic [3:0] dy,
    input logic [3:0] mx,
    input logic [3:0] my
  );
    port_e p;
    if (dx > mx)      p = P_EAST;
    else if (dx < mx) p = P_WEST;
    else if (dy > my) p = P_NORTH;
    else if (dy < my) p = P_SOUTH;
    else              p = P_LOCAL;
    return p;
  endfunction

endpackage

module router_xy_input
  import router_pkg::*;
#(
  parameter int BUS_W      = `ROUTER_BUS_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_tvalid,
  output logic                               s_tready,
  input  logic [BUS_W-1:0]                   s_tdata,
  input  logic                               s_tlast,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic [BUS_W-1:0]                   m_tdata,
  output logic                               m_tlast,
  output logic [2:0]                         m_port,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    level
);

  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [3:0] MX = 4'(MY_X);
  localparam logic [3:0] MY = 4'(MY_Y);

  logic [BUS_W:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [LW-1:0]  r_level;

  rt_state_e r_state;
  rt_state_e w_state_nx;
  port_e     r_route;
  port_e     w_route_nx;
  port_e     w_route_hd;
  port_e     w_port;

  logic           w_push;
  logic           w_pop;
  logic [BUS_W:0] w_head;
  logic [3:0]     w_dx;
  logic [3:0]     w_dy;

  assign s_tready = (r_level != FULL);
  assign m_tvalid = (r_level != '0);
  assign w_push   = s_tvalid & s_tready;
  assign w_pop    = m_tvalid & m_tready;

  assign w_head  = r_mem[r_rd];
  assign m_tdata = w_head[BUS_W-1:0];
  assign m_tlast = w_head[BUS_W];
  assign w_dx    = w_head[BUS_W-9 -: 4];
  assign w_dy    = w_head[BUS_W-13 -: 4];
  assign level   = r_level;
  assign m_port  = w_port;

  // Storage array; cleared so the empty head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr] <= {s_tlast, s_tdata};
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Packet state and held route.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HEAD;
      r_route <= P_LOCAL;
    end else begin
      r_state <= w_state_nx;
      r_route <= w_route_nx;
    end
  end

  // Next state, route latch and presented port.
  always_comb begin
    w_state_nx = r_state;
    w_route_nx = r_route;
    w_route_hd = route_xy(w_dx, w_dy, MX, MY);
    w_port     = P_LOCAL;
    unique case (r_state)
      S_HEAD: begin
        if (m_tvalid) w_port = w_route_hd;
        if (w_pop && !m_tlast) begin
          w_state_nx = S_BODY;
          w_route_nx = w_route_hd;
        end
      end
      S_BODY: begin
        if (m_tvalid) w_port = r_route;
        if (w_pop && m_tlast) begin
          w_state_nx = S_HEAD;
        end
      end
      default: begin
        w_state_nx = S_HEAD;
      end
    endcase
  end

endmodule
